// File: rtl/ready_gen_pkg.sv
// Shared types and helpers for the multi-channel ready generator.
package ready_gen_pkg;

    localparam int DEFAULT_DW = 4;

    typedef logic [DEFAULT_DW-1:0] ready_dly_t;

    // Index width for a channel select; never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ready_gen_ch.sv
// One ready-generator channel: saturating run-length counter against a loadable delay.
module ready_gen_ch
    import ready_gen_pkg::*;
#(
    parameter int DW     = DEFAULT_DW,
    parameter int STAGES = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ce_i,
    input  logic          i,
    input  logic          ld_i,
    input  logic [DW-1:0] ld_dly_i,
    output logic          o_reg,
    output logic          rise,
    output logic [DW-1:0] dly
);

    logic [DW-1:0] cnt;
    logic          o_nxt;

    // Compare against the delay currently held, so a same-edge load takes effect next edge.
    always_comb begin
        o_nxt = i && (cnt >= dly);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt   <= '0;
            o_reg <= 1'b0;
            rise  <= 1'b0;
            dly   <= DW'(STAGES);
        end else begin
            if (ld_i) begin
                dly <= ld_dly_i;
            end
            if (ce_i) begin
                if (!i) begin
                    cnt <= '0;
                end else if (cnt < dly) begin
                    cnt <= cnt + 1'b1;
                end
                o_reg <= o_nxt;
                rise  <= o_nxt & ~o_reg;
            end
        end
    end

endmodule

// File: rtl/ready_gen_mc.sv
// Multi-channel ready generator with runtime-loadable per-channel delay.
// Optional macro READY_GEN_COMB_CLEAR_EN gates ready combinationally with the live input.
module ready_gen_mc
    import ready_gen_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DW       = DEFAULT_DW,
    parameter int STAGES   = 3,
    localparam int LDW     = clog2_min1(CHANNELS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   ce_i,
    input  logic [CHANNELS-1:0]    i,
    input  logic                   ld_i,
    input  logic [LDW-1:0]         ld_ch_i,
    input  logic [DW-1:0]          ld_dly_i,
    output logic [CHANNELS-1:0]    o,
    output logic [CHANNELS-1:0]    rise_o,
    output logic [CHANNELS*DW-1:0] dly_o
);

    logic [CHANNELS-1:0] o_reg;
    logic [CHANNELS-1:0] ld_en;

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        // Out-of-range channel indices match no channel and are dropped here.
        assign ld_en[n] = ld_i && (int'(ld_ch_i) == n);

        ready_gen_ch #(
            .DW     (DW),
            .STAGES (STAGES)
        ) u_ch (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .ce_i     (ce_i),
            .i        (i[n]),
            .ld_i     (ld_en[n]),
            .ld_dly_i (ld_dly_i),
            .o_reg    (o_reg[n]),
            .rise     (rise_o[n]),
            .dly      (dly_o[n*DW +: DW])
        );
    end

`ifdef READY_GEN_COMB_CLEAR_EN
    assign o = o_reg & i;
`else
    assign o = o_reg;
`endif

endmodule

// File: tb/tb_ready_gen_mc.sv
// Directed self-checking bench for ready_gen_mc (5 channels so an out-of-range index is expressible).
module tb_ready_gen_mc;
    import ready_gen_pkg::*;

    localparam int CH  = 5;
    localparam int DW  = DEFAULT_DW;
    localparam int LDW = clog2_min1(CH);

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             ce_i;
    logic [CH-1:0]    i;
    logic             ld_i;
    logic [LDW-1:0]   ld_ch_i;
    ready_dly_t       ld_dly_i;
    logic [CH-1:0]    o;
    logic [CH-1:0]    rise_o;
    logic [CH*DW-1:0] dly_o;

    int n_chk  = 0;
    int n_pass = 0;

    ready_gen_mc #(
        .CHANNELS (CH),
        .DW       (DW),
        .STAGES   (3)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .ce_i     (ce_i),
        .i        (i),
        .ld_i     (ld_i),
        .ld_ch_i  (ld_ch_i),
        .ld_dly_i (ld_dly_i),
        .o        (o),
        .rise_o   (rise_o),
        .dly_o    (dly_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load(input int ch, input int val);
        ld_i     = 1'b1;
        ld_ch_i  = LDW'(ch);
        ld_dly_i = DW'(val);
        tick();
        ld_i     = 1'b0;
    endtask

    logic [CH-1:0] exp_o3 [7];
    logic [CH-1:0] exp_r3 [7];
    logic          ce_seq [7];

    initial begin
        rst_i = 1'b1; ce_i = 1'b1; i = '0; ld_i = 1'b0; ld_ch_i = '0; ld_dly_i = '0;
        tick(); tick();
        rst_i = 1'b0;
        chk("rst_o", 32'(o), 32'h0);
        chk("rst_rise", 32'(rise_o), 32'h0);
        chk("rst_dly", 32'(dly_o), 32'h33333);

        // ch0 with default delay 3: ready at the 4th edge
        i[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("ch0_o_e%0d", k), 32'(o), (k == 4) ? 32'h1 : 32'h0);
            chk($sformatf("ch0_rise_e%0d", k), 32'(rise_o), (k == 4) ? 32'h1 : 32'h0);
        end
        tick();
        chk("ch0_o_hold", 32'(o[0]), 32'h1);
        chk("ch0_rise_clr", 32'(rise_o[0]), 32'h0);

        // drop i[0] with ce low: comb-clear build drops at once, legacy waits for a ce edge
        ce_i = 1'b0; i[0] = 1'b0;
        #1;
`ifdef READY_GEN_COMB_CLEAR_EN
        chk("ch0_drop_now", 32'(o[0]), 32'h0);
        tick();
        chk("ch0_drop_ce0", 32'(o[0]), 32'h0);
`else
        chk("ch0_drop_now", 32'(o[0]), 32'h1);
        tick();
        chk("ch0_drop_ce0", 32'(o[0]), 32'h1);
`endif
        ce_i = 1'b1;
        tick();
        chk("ch0_drop_ce1", 32'(o[0]), 32'h0);

        // ch1: 3 high, 1 low, then a full restart of 4 edges
        i[1] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("ch1_run1_e%0d", k), 32'(o[1]), 32'h0);
        end
        i[1] = 1'b0;
        tick();
        chk("ch1_gap", 32'(o[1]), 32'h0);
        i[1] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("ch1_run2_e%0d", k), 32'(o[1]), (k == 4) ? 32'h1 : 32'h0);
        end
        i[1] = 1'b0;
        tick();
        chk("ch1_off", 32'(o), 32'h0);

        // ch2 delay 2 with ce toggling
        load(2, 2);
        chk("ch2_dly", 32'(dly_o[2*DW +: DW]), 32'h2);
        ce_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_o3 = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h04, 5'h04, 5'h04};
        exp_r3 = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h04, 5'h04, 5'h00};
        i[2] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            ce_i = ce_seq[k];
            tick();
            chk($sformatf("ch2_o_e%0d", k), 32'(o), 32'(exp_o3[k]));
            chk($sformatf("ch2_rise_e%0d", k), 32'(rise_o), 32'(exp_r3[k]));
        end
        ce_i = 1'b1; i[2] = 1'b0;
        tick();

        // ch3 delay 0, then reload to 7 while ready
        load(3, 0);
        i[3] = 1'b1;
        tick();
        chk("ch3_d0_o", 32'(o), 32'h08);
        chk("ch3_d0_rise", 32'(rise_o), 32'h08);
        load(3, 7);
        chk("ch3_ld_edge_o", 32'(o[3]), 32'h1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("ch3_d7_o_e%0d", k), 32'(o[3]), (k == 8) ? 32'h1 : 32'h0);
            chk($sformatf("ch3_d7_rise_e%0d", k), 32'(rise_o[3]), (k == 8) ? 32'h1 : 32'h0);
        end
        load(5, 9);
        load(7, 1);
        chk("ld_oob_dly", 32'(dly_o), 32'h37233);

        // reset mid-count with every input high
        i = '1;
        tick(); tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mid_rst_o", 32'(o), 32'h0);
        chk("mid_rst_rise", 32'(rise_o), 32'h0);
        chk("mid_rst_dly", 32'(dly_o), 32'h33333);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("post_rst_o_e%0d", k), 32'(o), (k == 4) ? 32'h1f : 32'h0);
            chk($sformatf("post_rst_rise_e%0d", k), 32'(rise_o), (k == 4) ? 32'h1f : 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ready_gen_mc.md
Name: ready_gen_mc

Overview:
Multi-channel successor to the single-channel ready generator. Each channel asserts its ready output after its input has been continuously high for a programmable number of clock-enabled cycles. The output drops as soon as the input is seen low. The per-channel delay is runtime-loadable, which replaces the fixed shift-register depth with a saturating counter. Sits between slow-settling sources (memory/IO decode, multicycle FU operand paths) and issue/commit logic.

Parameters:
CHANNELS, 4, number of independent channels (1..32)
DW, 4, width of per-channel delay value and counter
STAGES, 3, reset value of every channel's delay; must be < 2**DW

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
ce_i  in  1  clock enable; all channel state frozen when low
i  in  CHANNELS  per-channel request/condition input
ld_i  in  1  load strobe for a channel delay value
ld_ch_i  in  $clog2(CHANNELS) (min 1)  channel index for load
ld_dly_i  in  DW  delay value to load
o  out  CHANNELS  per-channel ready
rise_o  out  CHANNELS  one-cycle pulse on each 0->1 transition of o
dly_o  out  CHANNELS*DW  current delay registers, channel n at [n*DW +: DW]

Behaviour:
- Reset (rst_i high at an edge, regardless of ce_i): o=0, rise_o=0, all counters=0, all delays=STAGES. Reset mid-count discards progress.
- Per channel n, on each edge with ce_i=1 and rst_i=0:
  - i[n]=0 -> cnt=0, o[n]<=0.
  - i[n]=1 and cnt<dly -> cnt<=cnt+1, o[n]<=0.
  - i[n]=1 and cnt>=dly -> cnt holds (saturates, never wraps), o[n]<=1.
- Latency: o[n] rises on the (dly+1)th consecutive ce-qualified edge at which i[n] is sampled high. dly=0 gives a one-register copy of i. dly=STAGES=3 matches the legacy 3-stage generator, with o at the 4th edge.
- A single low sample of i restarts the full delay. Cycles with ce_i=0 neither count nor clear.
- rise_o[n] is a registered pulse: high for exactly one ce-qualified cycle, on the edge where o[n] goes 0->1.
  - Cleared on the next ce-qualified edge.
  - With ce_i=0 it is held along with o.
- Delay load: ld_i=1 at an edge writes ld_dly_i into channel ld_ch_i's delay.
  - Executes independent of ce_i, but not during rst_i.
  - ld_ch_i >= CHANNELS is ignored.
  - The new value is used from the next edge onward. The counter is not cleared.
  - Loading a value <= current cnt while i is high asserts o on the next ce-qualified edge.
  - Loading a value > cnt while o=1 deasserts o next ce edge, then re-counts from the saturated cnt toward the new dly.
- Simultaneous load and count on the same channel: the count/compare at that edge uses the old delay.
- Channels are fully independent; no shared arbitration.

Optional Feature:
Macro READY_GEN_COMB_CLEAR_EN.
- Defined: output o[n] = o_reg[n] & i[n], so ready drops combinationally in the same cycle i falls, independent of ce_i. rise_o is unchanged and stays registered.
- Undefined: o is the register directly, dropping at the first ce-qualified edge after i falls (legacy timing). o_reg and its reset are identical in both builds.

Decomposition:
- Package ready_gen_pkg holds:
  - default DW constant
  - typedef ready_dly_t (logic [DW-1:0])
  - function clog2_min1 for the ld_ch_i width
- Sub-module ready_gen_ch implements one channel (counter, delay register, o/rise registers, load enable).
- The top level generates CHANNELS instances and decodes ld_ch_i into per-channel load enables.

Test Plan:
- Reset then hold i[0]=1, ce_i=1 with default STAGES=3 -> o[0] high at the 4th edge after i rises; rise_o[0] pulses exactly at that edge; dly_o reads 3 for all channels.
- i[1] high 3 edges, low 1 edge, high again (dly=3) -> o[1] never asserts during the first run; asserts 4 edges after the re-rise.
- Toggle ce_i 1,0,1,0 while i[2]=1 (dly=2) -> only ce-high edges count; o[2] rises on the 3rd ce-high edge; rise_o holds through ce-low cycles.
- Load ch3 dly=0, then raise i[3] -> o[3] high after 1 edge. While o[3]=1, load dly=7 -> o[3] drops next edge, then re-asserts after counting reaches 7. Load ld_ch_i=CHANNELS -> no delay changes.
- Assert rst_i mid-count on all channels with i held high -> o=0, delays back to 3, full count restarts after reset release.
- With READY_GEN_COMB_CLEAR_EN, drop i[0] while o[0]=1 -> o[0] low in the same cycle (ce_i=0 as well). Without the macro -> o[0] low one ce-qualified edge later.
